// File: rtl/cpu_sequencer_if.sv
// Datapath control bundle between the sequencer and the processor datapath.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [15:0]      ins;
    logic             zero;
    logic             dm_ready;
    logic             start;
    logic             rstPC;
    logic             ldPC;
    logic             pcSel;
    logic             jumpSel;
    logic             branchSel;
    logic             regSel;
    logic             inSel;
    logic             selDm;
    logic             selALU;
    logic             regWrite;
    logic             nop;
    logic             ldWnd;
    logic [1:0]       wndCtrl;
    logic             memWrite;
    logic             memRead;
    logic [2:0]       funcCtrl;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  ins, zero, dm_ready, start,
        output rstPC, ldPC, pcSel, jumpSel, branchSel, regSel, inSel, selDm,
               selALU, regWrite, nop, ldWnd, wndCtrl, memWrite, memRead,
               funcCtrl, halted, fault, retired
    );

    modport slave (
        output ins, zero, dm_ready, start,
        input  rstPC, ldPC, pcSel, jumpSel, branchSel, regSel, inSel, selDm,
               selALU, regWrite, nop, ldWnd, wndCtrl, memWrite, memRead,
               funcCtrl, halted, fault, retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Control unit: instruction decode, boot PC reset, memory wait/timeout,
// halt/resume and retired-instruction counting.
module cpu_sequencer #(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic             clk,
    input logic             rst,
    cpu_sequencer_if.master bus
);

    localparam int unsigned BOOT_W = $clog2(BOOT_CYCLES + 1);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_ALUR  = 4'b1000;
    localparam logic [3:0] OP_WND   = 4'b1010;
    localparam logic [3:0] OP_ALUI  = 4'b1100;
    localparam logic [3:0] OP_NOP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BOOT_W-1:0]  boot_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               mem_load;
    logic               fault_q;
    logic [CNT_W-1:0]   retired_q;
    logic               retire;
    logic               timeout;
    logic               go_wait;
    logic [3:0]         op;
    logic               unused_ins;

    assign op         = bus.ins[15:12];
    // Instruction bits not consumed by any control decode.
    assign unused_ins = ^{bus.ins[11], bus.ins[7:3]};

    assign bus.fault   = fault_q;
    assign bus.retired = retired_q;

    // State register; reset overrides every other transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus retire/timeout/wait-entry events.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        timeout    = 1'b0;
        go_wait    = 1'b0;
        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                case (op)
                    OP_LOAD, OP_STORE: begin
                        if (bus.dm_ready) begin
                            retire = 1'b1;
                        end else begin
                            go_wait    = 1'b1;
                            next_state = ST_MEM_WAIT;
                        end
                    end
                    OP_HALT: begin
                        retire     = 1'b1;
                        next_state = ST_HALT;
                    end
                    default: retire = 1'b1;
                endcase
            end
            ST_MEM_WAIT: begin
                // dm_ready takes precedence over a coincident timeout.
                if (bus.dm_ready) begin
                    retire     = 1'b1;
                    next_state = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_BOOT;
        endcase
    end

    // Boot/wait counters, pending-access type, fault flag and retire counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            mem_load  <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            if (state == ST_BOOT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
            if (state == ST_MEM_WAIT && next_state == ST_MEM_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (go_wait) begin
                mem_load <= (op == OP_LOAD);
            end
            if (timeout) begin
                fault_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    // Datapath strobes from current state, instruction and handshake inputs.
    always_comb begin
        bus.rstPC     = 1'b0;
        bus.ldPC      = 1'b0;
        bus.pcSel     = 1'b0;
        bus.jumpSel   = 1'b0;
        bus.branchSel = 1'b0;
        bus.regSel    = 1'b0;
        bus.inSel     = 1'b0;
        bus.selDm     = 1'b0;
        bus.selALU    = 1'b0;
        bus.regWrite  = 1'b0;
        bus.nop       = 1'b1;
        bus.ldWnd     = 1'b0;
        bus.wndCtrl   = 2'b00;
        bus.memWrite  = 1'b0;
        bus.memRead   = 1'b0;
        bus.funcCtrl  = 3'b000;
        bus.halted    = 1'b0;
        case (state)
            ST_BOOT: bus.rstPC = 1'b1;
            ST_RUN: begin
                bus.ldPC  = 1'b1;
                bus.pcSel = 1'b1;
                case (op)
                    OP_LOAD: begin
                        bus.memRead  = 1'b1;
                        bus.selDm    = 1'b1;
                        bus.regWrite = bus.dm_ready;
                        bus.ldPC     = bus.dm_ready;
                    end
                    OP_STORE: begin
                        bus.memWrite = 1'b1;
                        bus.ldPC     = bus.dm_ready;
                    end
                    OP_JUMP: begin
                        bus.jumpSel = 1'b1;
                        bus.pcSel   = 1'b0;
                    end
                    OP_BRZ: begin
                        bus.branchSel = 1'b1;
                        bus.pcSel     = ~bus.zero;
                    end
                    OP_ALUR: begin
                        bus.regSel   = 1'b1;
                        bus.selALU   = 1'b1;
                        bus.regWrite = 1'b1;
                        bus.funcCtrl = bus.ins[2:0];
                    end
                    OP_ALUI: begin
                        bus.inSel    = 1'b1;
                        bus.selALU   = 1'b1;
                        bus.regWrite = 1'b1;
                        bus.funcCtrl = bus.ins[10:8];
                    end
                    OP_WND: begin
                        bus.ldWnd   = 1'b1;
                        bus.wndCtrl = bus.ins[1:0];
                    end
                    OP_HALT: bus.ldPC = 1'b1;
                    OP_NOP:  bus.nop  = 1'b0;
                    default: bus.nop  = 1'b0;
                endcase
            end
            ST_MEM_WAIT: begin
                // Strobes follow the access that entered the wait, not ins.
                bus.memRead  = mem_load;
                bus.selDm    = mem_load;
                bus.memWrite = ~mem_load;
                bus.pcSel    = 1'b1;
                bus.ldPC     = bus.dm_ready;
                bus.regWrite = bus.dm_ready & mem_load;
            end
            ST_HALT: bus.halted = 1'b1;
            default: bus.rstPC = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed-vector bench for cpu_sequencer with hand-computed expectations.
module tb_cpu_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   exp_ret;

    cpu_sequencer_if #(.CNT_W(16)) bus ();

    cpu_sequencer #(
        .BOOT_CYCLES(2),
        .MEM_TIMEOUT(15),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        exp_ret      = 0;
        rst          = 1'b0;
        bus.ins      = 16'hE000;
        bus.zero     = 1'b0;
        bus.dm_ready = 1'b0;
        bus.start    = 1'b0;

        // Reset held low for three edges
        repeat (3) tick();
        check("rst_rstPC", bus.rstPC, 1);
        check("rst_ldPC", bus.ldPC, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_halted", bus.halted, 0);

        // Release: exactly two BOOT cycles
        rst     = 1'b1;
        bus.ins = 16'h8003;
        #1;
        check("boot1_rstPC", bus.rstPC, 1);
        check("boot1_ldPC", bus.ldPC, 0);
        tick();
        check("boot2_rstPC", bus.rstPC, 1);
        check("boot2_ldPC", bus.ldPC, 0);
        tick();

        // ALU-R func 3
        check("alur_rstPC", bus.rstPC, 0);
        check("alur_ldPC", bus.ldPC, 1);
        check("alur_regSel", bus.regSel, 1);
        check("alur_regWrite", bus.regWrite, 1);
        check("alur_func", bus.funcCtrl, 3);
        check("alur_pcSel", bus.pcSel, 1);
        check("alur_ret0", bus.retired, 0);
        tick();
        exp_ret = 1;
        check("alur_ret1", bus.retired, exp_ret);

        // BRZ taken / not taken
        bus.ins  = 16'h4020;
        bus.zero = 1'b1;
        #1;
        check("brz_branchSel", bus.branchSel, 1);
        check("brz_taken_pcSel", bus.pcSel, 0);
        bus.zero = 1'b0;
        #1;
        check("brz_nt_pcSel", bus.pcSel, 1);
        tick();
        exp_ret++;

        // ALU-I, func from ins[10:8]=6
        bus.ins = 16'hC600;
        #1;
        check("alui_inSel", bus.inSel, 1);
        check("alui_func", bus.funcCtrl, 6);
        check("alui_regSel", bus.regSel, 0);
        tick();
        exp_ret++;

        // WND
        bus.ins = 16'hA002;
        #1;
        check("wnd_ldWnd", bus.ldWnd, 1);
        check("wnd_ctrl", bus.wndCtrl, 2);
        check("wnd_regWrite", bus.regWrite, 0);
        tick();
        exp_ret++;

        // JUMP
        bus.ins = 16'h2000;
        #1;
        check("jmp_jumpSel", bus.jumpSel, 1);
        check("jmp_pcSel", bus.pcSel, 0);
        tick();
        exp_ret++;

        // Undefined opcode behaves as NOP
        bus.ins = 16'h3000;
        #1;
        check("undef_nop", bus.nop, 0);
        check("undef_ldPC", bus.ldPC, 1);
        tick();
        exp_ret++;
        check("undef_ret", bus.retired, exp_ret);

        // LOAD with three not-ready cycles then ready
        bus.ins = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_wait_memRead", bus.memRead, 1);
            check("ld_wait_ldPC", bus.ldPC, 0);
            check("ld_wait_regWrite", bus.regWrite, 0);
            check("ld_wait_ret", bus.retired, exp_ret);
            tick();
        end
        bus.dm_ready = 1'b1;
        #1;
        check("ld_done_memRead", bus.memRead, 1);
        check("ld_done_selDm", bus.selDm, 1);
        check("ld_done_ldPC", bus.ldPC, 1);
        check("ld_done_regWrite", bus.regWrite, 1);
        check("ld_done_ret", bus.retired, exp_ret);
        tick();
        exp_ret++;
        check("ld_after_ret", bus.retired, exp_ret);

        // STORE completing immediately
        bus.ins = 16'h1000;
        #1;
        check("st_fast_memWrite", bus.memWrite, 1);
        check("st_fast_ldPC", bus.ldPC, 1);
        tick();
        exp_ret++;
        bus.dm_ready = 1'b0;

        // STORE: ready arrives on the 15th wait cycle, beating the timeout
        #1;
        check("st_run_ldPC", bus.ldPC, 0);
        tick();
        for (int i = 0; i < 14; i++) begin
            check("st_edge_memWrite", bus.memWrite, 1);
            tick();
        end
        bus.dm_ready = 1'b1;
        #1;
        check("st_edge_ldPC", bus.ldPC, 1);
        check("st_edge_halted", bus.halted, 0);
        tick();
        exp_ret++;
        check("st_edge_fault", bus.fault, 0);
        check("st_edge_halted2", bus.halted, 0);
        check("st_edge_ret", bus.retired, exp_ret);
        bus.dm_ready = 1'b0;

        // STORE timeout after 15 wait cycles
        #1;
        tick();
        for (int i = 0; i < 15; i++) begin
            check("st_to_memWrite", bus.memWrite, 1);
            check("st_to_fault0", bus.fault, 0);
            check("st_to_halted0", bus.halted, 0);
            tick();
        end
        check("st_to_fault", bus.fault, 1);
        check("st_to_halted", bus.halted, 1);
        check("st_to_memWrite0", bus.memWrite, 0);
        check("st_to_ldPC", bus.ldPC, 0);
        check("st_to_ret", bus.retired, exp_ret);
        tick();
        check("halt_hold", bus.halted, 1);

        // Resume after fault
        bus.ins   = 16'h8003;
        bus.start = 1'b1;
        #1;
        check("halt_regWrite", bus.regWrite, 0);
        tick();
        bus.start = 1'b0;
        check("resume_halted", bus.halted, 0);
        check("resume_fault", bus.fault, 1);
        check("resume_regWrite", bus.regWrite, 1);
        tick();
        exp_ret++;

        // HALT opcode
        bus.ins = 16'hF000;
        #1;
        check("hop_ldPC", bus.ldPC, 1);
        tick();
        exp_ret++;
        check("hop_halted", bus.halted, 1);
        check("hop_ldPC_h", bus.ldPC, 0);
        check("hop_ret", bus.retired, exp_ret);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        // Reset mid MEM_WAIT
        bus.ins = 16'h0000;
        #1;
        tick();
        check("mw_memRead", bus.memRead, 1);
        check("mw_halted", bus.halted, 0);
        rst = 1'b0;
        #1;
        check("mw_pre_memRead", bus.memRead, 1);
        tick();
        check("mwrst_rstPC", bus.rstPC, 1);
        check("mwrst_memRead", bus.memRead, 0);
        check("mwrst_retired", bus.retired, 0);
        check("mwrst_fault", bus.fault, 0);
        rst = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
